// File: rtl/button_pkg.sv
// Shared channel indices, repeat-FSM encoding and default timing for the button debouncer.
package button_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int BTN_RESET  = 5;

    localparam int NUM_BTN = BTN_RESET + 1;
    // Directional channels occupy the low bits and are the only ones that auto-repeat.
    localparam int NUM_DIR = BTN_RIGHT + 1;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 15000000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rptState_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit synchronizer + debouncer with registered press/release strobes.
// Latency: DEBOUNCE_CYCLES+2 clocks from a stable raw change to level/pulse.
// Backpressure: none; free-running, pulses are one cycle and cannot be stalled.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic resetN,
    input  logic btnRaw,
    output logic level,
    output logic pressPulse,
    output logic releasePulse,
    output logic accRise,
    output logic accFall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // accRise/accFall are the unregistered accept strobes so the repeat FSM can act on the same edge.
    assign accept  = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign accRise = accept && !level;
    assign accFall = accept && level;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            cnt          <= '0;
            level        <= 1'b0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
        end else begin
            sync1        <= btnRaw;
            sync2        <= sync1;
            pressPulse   <= accRise;
            releasePulse <= accFall;
            if ((sync2 == level) || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (accept) begin
                level <= ~level;
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Six-channel button debouncer with auto-repeat on the four directional buttons.
// Latency: DEBOUNCE_CYCLES+2 clocks to level/press/release; repeats after REPEAT_DELAY then every REPEAT_PERIOD.
// Backpressure: none; all outputs are single-cycle strobes or levels.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [NUM_BTN-1:0] btnIn,
    output logic [NUM_BTN-1:0] btnLevel,
    output logic [NUM_BTN-1:0] btnPress,
    output logic [NUM_BTN-1:0] btnRelease
);

    localparam int RW = $clog2(maxOf(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    logic [NUM_BTN-1:0] chanPress;
    logic [NUM_BTN-1:0] accRise;
    logic [NUM_BTN-1:0] accFall;
    logic [NUM_DIR-1:0] rptPulse;
    rptState_t          rptState [NUM_DIR];
    logic [RW-1:0]      rptCnt   [NUM_DIR];
    logic               unusedStrobes;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gChan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uChan (
            .clk         (clk),
            .resetN      (resetN),
            .btnRaw      (btnIn[g]),
            .level       (btnLevel[g]),
            .pressPulse  (chanPress[g]),
            .releasePulse(btnRelease[g]),
            .accRise     (accRise[g]),
            .accFall     (accFall[g])
        );
    end

    assign unusedStrobes = ^{accRise[NUM_BTN-1:NUM_DIR], accFall[NUM_BTN-1:NUM_DIR]};

    assign btnPress = chanPress | {{(NUM_BTN - NUM_DIR){1'b0}}, rptPulse};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rptPulse <= '0;
            for (int i = 0; i < NUM_DIR; i++) begin
                rptState[i] <= RPT_IDLE;
                rptCnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIR; i++) begin
                rptPulse[i] <= 1'b0;
                // A release wins over any repeat that would fire on the same edge.
                if (accFall[i]) begin
                    rptState[i] <= RPT_IDLE;
                    rptCnt[i]   <= '0;
                end else begin
                    case (rptState[i])
                        RPT_IDLE: begin
                            if (accRise[i] && (REPEAT_EN != 0)) begin
                                rptState[i] <= RPT_DELAY;
                                rptCnt[i]   <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (rptCnt[i] == RW'(REPEAT_DELAY - 1)) begin
                                rptPulse[i] <= 1'b1;
                                rptState[i] <= RPT_REPEAT;
                                rptCnt[i]   <= '0;
                            end else begin
                                rptCnt[i] <= rptCnt[i] + RW'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (rptCnt[i] == RW'(REPEAT_PERIOD - 1)) begin
                                rptPulse[i] <= 1'b1;
                                rptCnt[i]   <= '0;
                            end else begin
                                rptCnt[i] <= rptCnt[i] + RW'(1);
                            end
                        end
                        default: begin
                            rptState[i] <= RPT_IDLE;
                            rptCnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
// Cycle k is observed at the k-th falling edge after a scenario starts; inputs change at that same edge.
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       resetN;
    logic [5:0] btnIn;
    logic [5:0] btnLevel;
    logic [5:0] btnPress;
    logic [5:0] btnRelease;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .btnIn     (btnIn),
        .btnLevel  (btnLevel),
        .btnPress  (btnPress),
        .btnRelease(btnRelease)
    );

    task automatic test_reset();
        resetN = 1'b0;
        btnIn  = 6'h3F;
        repeat (3) @(negedge clk);
        total++; if (btnLevel !== 6'b0) begin bad++; $display("FAIL reset_level got=%b exp=%b", btnLevel, 6'b0); end
        total++; if (btnPress !== 6'b0) begin bad++; $display("FAIL reset_press got=%b exp=%b", btnPress, 6'b0); end
        total++; if (btnRelease !== 6'b0) begin bad++; $display("FAIL reset_release got=%b exp=%b", btnRelease, 6'b0); end
        btnIn  = 6'b0;
        resetN = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (btnLevel !== 6'b0) begin bad++; $display("FAIL idle_level got=%b exp=%b", btnLevel, 6'b0); end
        total++; if (btnPress !== 6'b0) begin bad++; $display("FAIL idle_press got=%b exp=%b", btnPress, 6'b0); end
    endtask

    // Center press held 10 cycles: one press at 6, release at 16, never a repeat.
    task automatic test_single_press();
        logic [5:0] expLevel, expPress, expRelease;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            expLevel   = (k >= 6 && k <= 15) ? 6'b010000 : 6'b0;
            expPress   = (k == 6)  ? 6'b010000 : 6'b0;
            expRelease = (k == 16) ? 6'b010000 : 6'b0;
            total++; if (btnLevel !== expLevel) begin bad++; $display("FAIL single_level k=%0d got=%b exp=%b", k, btnLevel, expLevel); end
            total++; if (btnPress !== expPress) begin bad++; $display("FAIL single_press k=%0d got=%b exp=%b", k, btnPress, expPress); end
            total++; if (btnRelease !== expRelease) begin bad++; $display("FAIL single_release k=%0d got=%b exp=%b", k, btnRelease, expRelease); end
            btnIn = (k <= 9) ? 6'b010000 : 6'b0;
        end
    endtask

    // Down bounces 1,0,1,0,1 then holds; released before the repeat delay expires.
    task automatic test_bounce();
        logic [5:0] expLevel, expPress, expRelease;
        logic [4:0] pattern;
        pattern = 5'b10101;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            expLevel   = (k >= 10 && k <= 16) ? 6'b000010 : 6'b0;
            expPress   = (k == 10) ? 6'b000010 : 6'b0;
            expRelease = (k == 17) ? 6'b000010 : 6'b0;
            total++; if (btnLevel !== expLevel) begin bad++; $display("FAIL bounce_level k=%0d got=%b exp=%b", k, btnLevel, expLevel); end
            total++; if (btnPress !== expPress) begin bad++; $display("FAIL bounce_press k=%0d got=%b exp=%b", k, btnPress, expPress); end
            total++; if (btnRelease !== expRelease) begin bad++; $display("FAIL bounce_release k=%0d got=%b exp=%b", k, btnRelease, expRelease); end
            if (k <= 4)       btnIn = {4'b0, pattern[k], 1'b0};
            else if (k <= 10) btnIn = 6'b000010;
            else              btnIn = 6'b0;
        end
    endtask

    // A 3-cycle pulse is one sample short of acceptance.
    task automatic test_glitch();
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            total++; if (btnLevel !== 6'b0) begin bad++; $display("FAIL glitch_level k=%0d got=%b exp=%b", k, btnLevel, 6'b0); end
            total++; if (btnPress !== 6'b0) begin bad++; $display("FAIL glitch_press k=%0d got=%b exp=%b", k, btnPress, 6'b0); end
            total++; if (btnRelease !== 6'b0) begin bad++; $display("FAIL glitch_release k=%0d got=%b exp=%b", k, btnRelease, 6'b0); end
            btnIn = (k <= 2) ? 6'b100000 : 6'b0;
        end
    endtask

    // Up held cycles 0..29: level stays 1 until the release at 36, so repeats keep coming until then.
    task automatic test_repeat();
        logic [5:0] expLevel, expPress, expRelease;
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            expLevel   = (k >= 6 && k <= 35) ? 6'b000001 : 6'b0;
            expPress   = (k == 6 || (k >= 14 && k <= 35 && (k - 14) % 3 == 0)) ? 6'b000001 : 6'b0;
            expRelease = (k == 36) ? 6'b000001 : 6'b0;
            total++; if (btnLevel !== expLevel) begin bad++; $display("FAIL repeat_level k=%0d got=%b exp=%b", k, btnLevel, expLevel); end
            total++; if (btnPress !== expPress) begin bad++; $display("FAIL repeat_press k=%0d got=%b exp=%b", k, btnPress, expPress); end
            total++; if (btnRelease !== expRelease) begin bad++; $display("FAIL repeat_release k=%0d got=%b exp=%b", k, btnRelease, expRelease); end
            btnIn = (k <= 29) ? 6'b000001 : 6'b0;
        end
    endtask

    // Left held into REPEAT, reset during cycles 16..19, re-accepted as a fresh press at 26.
    task automatic test_reset_mid();
        logic [5:0] expLevel, expPress, expRelease;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            expLevel   = ((k >= 6 && k <= 16) || (k >= 26 && k <= 32)) ? 6'b000100 : 6'b0;
            expPress   = (k == 6 || k == 14 || k == 26) ? 6'b000100 : 6'b0;
            expRelease = (k == 33) ? 6'b000100 : 6'b0;
            total++; if (btnLevel !== expLevel) begin bad++; $display("FAIL rstmid_level k=%0d got=%b exp=%b", k, btnLevel, expLevel); end
            total++; if (btnPress !== expPress) begin bad++; $display("FAIL rstmid_press k=%0d got=%b exp=%b", k, btnPress, expPress); end
            total++; if (btnRelease !== expRelease) begin bad++; $display("FAIL rstmid_release k=%0d got=%b exp=%b", k, btnRelease, expRelease); end
            btnIn = (k <= 26) ? 6'b000100 : 6'b0;
            if (k == 16) begin
                resetN = 1'b0;
                #1;
                total++; if (btnLevel !== 6'b0) begin bad++; $display("FAIL rstmid_async_level got=%b exp=%b", btnLevel, 6'b0); end
                total++; if (btnPress !== 6'b0) begin bad++; $display("FAIL rstmid_async_press got=%b exp=%b", btnPress, 6'b0); end
                total++; if (btnRelease !== 6'b0) begin bad++; $display("FAIL rstmid_async_release got=%b exp=%b", btnRelease, 6'b0); end
            end
            if (k == 20) resetN = 1'b1;
        end
    endtask

    // Right and center together: shared press edge, shared release edge, no repeat on right.
    task automatic test_back_to_back();
        logic [5:0] expLevel, expPress, expRelease;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            expLevel   = (k >= 6 && k <= 12) ? 6'b011000 : 6'b0;
            expPress   = (k == 6)  ? 6'b011000 : 6'b0;
            expRelease = (k == 13) ? 6'b011000 : 6'b0;
            total++; if (btnLevel !== expLevel) begin bad++; $display("FAIL simul_level k=%0d got=%b exp=%b", k, btnLevel, expLevel); end
            total++; if (btnPress !== expPress) begin bad++; $display("FAIL simul_press k=%0d got=%b exp=%b", k, btnPress, expPress); end
            total++; if (btnRelease !== expRelease) begin bad++; $display("FAIL simul_release k=%0d got=%b exp=%b", k, btnRelease, expRelease); end
            btnIn = (k <= 6) ? 6'b011000 : 6'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_glitch();
        test_repeat();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
